// File: rtl/iter_muldiv.sv
// iter_muldiv: iterative RV32M multiply/divide unit for the execute stage.
//   Multiplies by shift-add and divides by restoring division on operand
//   magnitudes, one bit per cycle (32 busy cycles). The sign is fixed up at
//   the end. Divide-by-zero and signed overflow finish in a single cycle.
// Ports:
//   clk       - clock, all state on rising edge
//   rst       - asynchronous active-low reset
//   alu_opE   - execute-stage ALU op (M-ops 01011..10010)
//   SrcAE     - rs1 operand (multiplicand / dividend)
//   SrcBE     - rs2 operand (multiplier / divisor)
//   flush     - aborts a running operation
//   mul_use   - stall request while an M-op result is pending
//   flagM     - one-cycle strobe, result_m valid
//   result_m  - M-op result, held until the next flagM
module iter_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      alu_opE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            flush,
    output logic            mul_use,
    output logic            flagM,
    output logic [XLEN-1:0] result_m
);

    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_DIVU   = 5'b10000;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;
    localparam int         CW        = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [4:0]        op_q;
    logic              neg_a;     // rs1 was negative: remainder sign
    logic              neg_x;     // product / quotient sign
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   dvsr;

    // Decode of the incoming op
    logic            is_m, is_mul, is_rem, a_signed, b_signed, sa, sb;
    logic            start, special;
    logic [XLEN-1:0] mag_a, mag_b, spec_res;

    always_comb begin
        is_m     = alu_opE inside {[OP_MUL:OP_REMU]};
        is_mul   = alu_opE inside {[OP_MUL:OP_MULHU]};
        is_rem   = (alu_opE == OP_REM) || (alu_opE == OP_REMU);
        a_signed = alu_opE inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_signed = alu_opE inside {OP_MULH, OP_DIV, OP_REM};
        sa       = a_signed & SrcAE[XLEN-1];
        sb       = b_signed & SrcBE[XLEN-1];
        mag_a    = sa ? -SrcAE : SrcAE;
        mag_b    = sb ? -SrcBE : SrcBE;
        start    = is_m & ~flush;
        special  = 1'b0;
        spec_res = '0;
        if (!is_mul && SrcBE == '0) begin
            special  = 1'b1;
            spec_res = is_rem ? SrcAE : '1;
        end else if ((alu_opE == OP_DIV || alu_opE == OP_REM) &&
                     SrcAE == {1'b1, {(XLEN-1){1'b0}}} && SrcBE == '1) begin
            special  = 1'b1;
            spec_res = is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One iteration of both datapaths; op_q picks which one is used
    logic [2*XLEN-1:0] prod_n, mul_full;
    logic [XLEN:0]     r_shift, diff;
    logic [XLEN-1:0]   quo_n, rem_n, final_res;
    logic              last;

    always_comb begin
        prod_n   = mplier[0] ? prod + mcand : prod;
        mul_full = neg_x ? -prod_n : prod_n;
        r_shift  = {rem, quo[XLEN-1]};
        diff     = r_shift - {1'b0, dvsr};
        if (!diff[XLEN]) begin
            rem_n = diff[XLEN-1:0];
            quo_n = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_n = r_shift[XLEN-1:0];
            quo_n = {quo[XLEN-2:0], 1'b0};
        end
        last = (cnt == CW'(XLEN-1));
        case (op_q)
            OP_MUL:                      final_res = mul_full[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = mul_full[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             final_res = neg_x ? -quo_n : quo_n;
            default:                     final_res = neg_a ? -rem_n : rem_n;
        endcase
    end

    // Stall is raised combinationally in the capture cycle so the pipeline
    // freezes before the first busy cycle.
    assign mul_use = rst & ((state == BUSY) | ((state == IDLE) & start));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            neg_a    <= 1'b0;
            neg_x    <= 1'b0;
            prod     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            quo      <= '0;
            rem      <= '0;
            dvsr     <= '0;
            flagM    <= 1'b0;
            result_m <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= alu_opE;
                        neg_a <= sa;
                        neg_x <= sa ^ sb;
                        cnt   <= '0;
                        if (special) begin
                            result_m <= spec_res;
                            flagM    <= 1'b1;
                            state    <= DONE;
                        end else begin
                            prod   <= '0;
                            mcand  <= {{XLEN{1'b0}}, mag_a};
                            mplier <= mag_b;
                            quo    <= mag_a;
                            rem    <= '0;
                            dvsr   <= mag_b;
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        prod   <= prod_n;
                        mcand  <= {mcand[2*XLEN-2:0], 1'b0};
                        mplier <= {1'b0, mplier[XLEN-1:1]};
                        quo    <= quo_n;
                        rem    <= rem_n;
                        cnt    <= cnt + 1'b1;
                        if (last) begin
                            result_m <= final_res;
                            flagM    <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    flagM <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_muldiv.sv
module tb_iter_muldiv;

    localparam logic [4:0] MUL    = 5'b01011;
    localparam logic [4:0] MULH   = 5'b01100;
    localparam logic [4:0] MULHSU = 5'b01101;
    localparam logic [4:0] MULHU  = 5'b01110;
    localparam logic [4:0] DIV    = 5'b01111;
    localparam logic [4:0] DIVU   = 5'b10000;
    localparam logic [4:0] REM    = 5'b10001;
    localparam logic [4:0] REMU   = 5'b10010;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  alu_opE;
    logic [31:0] SrcAE, SrcBE;
    logic        flush;
    logic        mul_use, flagM;
    logic [31:0] result_m;

    iter_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .alu_opE(alu_opE), .SrcAE(SrcAE), .SrcBE(SrcBE),
        .flush(flush), .mul_use(mul_use), .flagM(flagM), .result_m(result_m)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { logic [31:0] res; int cyc; } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    logic [31:0] last_exp = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on sign/zero-extended operands
    function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sbv, ub;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ub  = longint'({32'b0, b});
        case (op)
            MUL:    begin p = sa * sbv; return p[31:0]; end
            MULH:   begin p = sa * sbv; return p[63:32]; end
            MULHSU: begin p = sa * ub;  return p[63:32]; end
            MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            DIV:    begin if (b == 0) return 32'hFFFFFFFF; p = sa / sbv; return p[31:0]; end
            DIVU:   begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
            REM:    begin if (b == 0) return a; p = sa % sbv; return p[31:0]; end
            REMU:   begin if (b == 0) return a; return a % b; end
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op inside {DIV, DIVU, REM, REMU} && b == 0) return 1;
        if (op inside {DIV, REM} && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    // Monitor: every flagM strobe must match the oldest expected result
    always @(negedge clk) begin
        if (rst === 1'b1 && flagM === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_flagM", 32'(flagM), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_m", result_m, e.res);
                check("flagM_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issue one M-op and follow it to completion; garbage on the inputs
    // while busy must be ignored.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        exp_t e;
        @(posedge clk); #1;
        alu_opE = op; SrcAE = a; SrcBE = b;
        lat   = ref_lat(op, a, b);
        e.res = ref_res(op, a, b);
        e.cyc = cyc + lat;
        sb.push_back(e);
        #1 check("mul_use_c0", 32'(mul_use), 32'h1);
        for (int i = 1; i <= lat; i++) begin
            @(posedge clk); #1;
            if (i < lat) begin
                alu_opE = 5'($urandom);
                SrcAE   = $urandom;
                SrcBE   = $urandom;
            end else begin
                alu_opE = 5'b00000;
            end
            #1 check("mul_use_run", 32'(mul_use), (i < lat) ? 32'h1 : 32'h0);
        end
        last_exp = e.res;
    endtask

    task automatic start_untracked(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input int stop_cyc);
        @(posedge clk); #1;
        alu_opE = op; SrcAE = a; SrcBE = b;
        for (int i = 1; i <= stop_cyc; i++) begin
            @(posedge clk); #1;
            alu_opE = 5'b00000;
        end
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] a, b;
        logic [31:0] corner [4];
        corner[0] = 32'h0; corner[1] = 32'h80000000; corner[2] = 32'hFFFFFFFF; corner[3] = 32'h1;

        rst = 1'b0; flush = 1'b0; alu_opE = MUL; SrcAE = 32'd3; SrcBE = 32'd4;
        #3;
        check("rst_mul_use", 32'(mul_use), 32'h0);
        check("rst_flagM", 32'(flagM), 32'h0);
        check("rst_result", result_m, 32'h0);
        alu_opE = 5'b00000;
        #14 rst = 1'b1;

        // non-M op in IDLE
        @(posedge clk); #1;
        alu_opE = 5'b00011; SrcAE = 32'd9; SrcBE = 32'd0;
        #1 check("nonm_mul_use", 32'(mul_use), 32'h0);
        @(posedge clk); #2 check("nonm_mul_use2", 32'(mul_use), 32'h0);
        alu_opE = 5'b00000;

        // directed vectors
        run_op(MUL,    32'd7,        32'hFFFFFFFD);
        run_op(MULH,   32'h80000000, 32'h80000000);
        run_op(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op(DIV,    32'hFFFFFFF9, 32'd2);
        run_op(REM,    32'hFFFFFFF9, 32'd2);
        run_op(DIVU,   32'd100,      32'd7);
        run_op(REMU,   32'd100,      32'd7);
        run_op(DIVU,   32'd5,        32'd0);
        run_op(REM,    32'd5,        32'd0);
        run_op(DIV,    32'h80000000, 32'hFFFFFFFF);
        run_op(REM,    32'h80000000, 32'hFFFFFFFF);

        // flush at cycle 10: back in IDLE at 11, result held, no strobe
        start_untracked(MUL, 32'd11, 32'd13, 9);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        #1;
        check("flush_mul_use", 32'(mul_use), 32'h0);
        check("flush_flagM", 32'(flagM), 32'h0);
        check("flush_hold", result_m, last_exp);
        flush = 1'b0;
        repeat (40) @(posedge clk);
        #1 check("flush_hold_late", result_m, last_exp);

        // flush together with an M-op in IDLE: nothing starts
        alu_opE = MUL; SrcAE = 32'd2; SrcBE = 32'd2; flush = 1'b1;
        #1 check("flush_idle_mul_use", 32'(mul_use), 32'h0);
        @(posedge clk); #2 check("flush_idle_mul_use2", 32'(mul_use), 32'h0);
        alu_opE = 5'b00000; flush = 1'b0;
        @(posedge clk); #2 check("flush_idle_stays", 32'(mul_use), 32'h0);

        // reset at busy cycle 20
        start_untracked(MUL, 32'd9, 32'd9, 20);
        rst = 1'b0;
        #1;
        check("rst_busy_mul_use", 32'(mul_use), 32'h0);
        check("rst_busy_flagM", 32'(flagM), 32'h0);
        check("rst_busy_result", result_m, 32'h0);
        last_exp = '0;
        @(posedge clk); #1 rst = 1'b1;
        run_op(MUL, 32'd3, 32'd4);

        // back-to-back
        run_op(MUL, 32'd2, 32'd3);
        run_op(MUL, 32'd5, 32'd6);

        // randomized
        for (int n = 0; n < 40; n++) begin
            op = 5'(MUL + $urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
            run_op(op, a, b);
        end

        repeat (3) @(posedge clk);
        #2 check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
